// File: rtl/i2c_reg_sequencer.sv
// I2C register sequencer: writes an init table to one slave, then polls a
// burst of single-byte register reads forever, publishing each complete
// burst atomically. Transactions that NACK are retried a bounded number of
// times before the block parks in ERROR until the next start pulse.
module i2c_reg_sequencer #(
   parameter logic [6:0] SLAVE_ADDR = 7'h68,
   parameter int         NUM_INIT   = 3,
   parameter int         NUM_READ   = 6,
   parameter logic [7:0] READ_BASE  = 8'h3B,
   parameter int         POLL_DIV   = 12000,
   parameter int         MAX_RETRY  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [NUM_INIT*8-1:0] init_addrs,
   input  logic [NUM_INIT*8-1:0] init_datas,
   output logic                  drv_req,
   output logic [6:0]            drv_slave_addr,
   output logic                  drv_r_en,
   output logic [7:0]            drv_reg_addr,
   output logic [7:0]            drv_wdata,
   input  logic [7:0]            drv_rdata,
   input  logic                  drv_done,
   input  logic                  drv_nack,
   output logic [NUM_READ*8-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  init_done,
   output logic                  busy,
   output logic                  error
);

   localparam int MAX_N = (NUM_INIT > NUM_READ) ? NUM_INIT : NUM_READ;
   localparam int IW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
   localparam int TW    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT_ISSUE,
      S_INIT_WAIT,
      S_POLL_WAIT,
      S_READ_ISSUE,
      S_READ_WAIT,
      S_ERROR
   } state_e;

   state_e                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [RW-1:0]         retry_q, retry_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  req_q, req_d;
   logic                  r_en_q, r_en_d;
   logic [7:0]            reg_addr_q, reg_addr_d;
   logic [7:0]            wdata_q, wdata_d;
   logic [NUM_READ*8-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  init_done_q, init_done_d;
   logic [7:0]            shadow_q [NUM_READ];
   logic                  shadow_we;
   logic [7:0]            init_addr_sel, init_data_sel;
   logic [NUM_READ*8-1:0] burst_word;
   logic                  drv_fire;

   // A completion only counts while a request is actually outstanding.
   assign drv_fire = drv_done & req_q;

   // Select the init table entry addressed by the current index.
   always_comb begin
      init_addr_sel = 8'h00;
      init_data_sel = 8'h00;
      for (int i = 0; i < NUM_INIT; i++) begin
         if (idx_q == IW'(i)) begin
            init_addr_sel = init_addrs[8*i +: 8];
            init_data_sel = init_datas[8*i +: 8];
         end
      end
   end

   // Assemble the published burst; the last byte arrives straight from the driver.
   always_comb begin
      burst_word = '0;
      for (int i = 0; i < NUM_READ; i++) begin
         burst_word[8*i +: 8] = (i == NUM_READ - 1) ? drv_rdata : shadow_q[i];
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      // NOTE: every _d gets a hold/default value first so no path leaves it unassigned, which would infer a latch.
      state_d     = state_q;
      idx_d       = idx_q;
      retry_d     = retry_q;
      timer_d     = timer_q;
      req_d       = req_q;
      r_en_d      = r_en_q;
      reg_addr_d  = reg_addr_q;
      wdata_d     = wdata_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      init_done_d = init_done_q;
      shadow_we   = 1'b0;

      case (state_q)
         S_IDLE, S_ERROR: begin
            if (start) begin
               state_d     = S_INIT_ISSUE;
               idx_d       = '0;
               retry_d     = '0;
               init_done_d = 1'b0;
            end
         end

         S_INIT_ISSUE: begin
            req_d      = 1'b1;
            r_en_d     = 1'b0;
            reg_addr_d = init_addr_sel;
            wdata_d    = init_data_sel;
            state_d    = S_INIT_WAIT;
         end

         S_INIT_WAIT: begin
            if (drv_fire) begin
               req_d = 1'b0;
               if (!drv_nack) begin
                  retry_d = '0;
                  if (idx_q == IW'(NUM_INIT - 1)) begin
                     init_done_d = 1'b1;
                     timer_d     = '0;
                     state_d     = S_POLL_WAIT;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     state_d = S_INIT_ISSUE;
                  end
               end else if (retry_q >= RW'(MAX_RETRY)) begin
                  state_d = S_ERROR;
               end else begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_INIT_ISSUE;
               end
            end
         end

         S_POLL_WAIT: begin
            if (timer_q == TW'(POLL_DIV - 1)) begin
               idx_d   = '0;
               state_d = S_READ_ISSUE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         S_READ_ISSUE: begin
            req_d      = 1'b1;
            r_en_d     = 1'b1;
            reg_addr_d = READ_BASE + 8'(idx_q);
            wdata_d    = 8'h00;
            state_d    = S_READ_WAIT;
         end

         S_READ_WAIT: begin
            if (drv_fire) begin
               req_d = 1'b0;
               if (!drv_nack) begin
                  retry_d   = '0;
                  shadow_we = 1'b1;
                  if (idx_q == IW'(NUM_READ - 1)) begin
                     rd_data_d  = burst_word;
                     rd_valid_d = 1'b1;
                     timer_d    = '0;
                     state_d    = S_POLL_WAIT;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     state_d = S_READ_ISSUE;
                  end
               end else if (retry_q >= RW'(MAX_RETRY)) begin
                  state_d = S_ERROR;
               end else begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_READ_ISSUE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State, counters and driver-facing outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         retry_q     <= '0;
         timer_q     <= '0;
         req_q       <= 1'b0;
         r_en_q      <= 1'b0;
         reg_addr_q  <= 8'h00;
         wdata_q     <= 8'h00;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
         state_q     <= state_d;
         idx_q       <= idx_d;
         retry_q     <= retry_d;
         timer_q     <= timer_d;
         req_q       <= req_d;
         r_en_q      <= r_en_d;
         reg_addr_q  <= reg_addr_d;
         wdata_q     <= wdata_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         init_done_q <= init_done_d;
      end
   end

   // Capture read bytes of the burst in progress.
   // NOTE: the shadow buffer has no reset; it is only observable after being fully rewritten by a burst.
   always_ff @(posedge clk) begin
      if (shadow_we) begin
         for (int i = 0; i < NUM_READ; i++) begin
            if (idx_q == IW'(i)) shadow_q[i] <= drv_rdata;
         end
      end
   end

   assign drv_req        = req_q;
   assign drv_slave_addr = SLAVE_ADDR;
   assign drv_r_en       = r_en_q;
   assign drv_reg_addr   = reg_addr_q;
   assign drv_wdata      = wdata_q;
   assign rd_data        = rd_data_q;
   assign rd_valid       = rd_valid_q;
   assign init_done      = init_done_q;
   assign busy           = (state_q != S_IDLE) && (state_q != S_ERROR);
   assign error          = (state_q == S_ERROR);

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: a behavioural driver answers each request,
// and a scoreboard holds the transactions and bursts expected from the
// sequencer, popped as the DUT issues requests or pulses rd_valid.
module tb_i2c_reg_sequencer;

   localparam logic [6:0] SLAVE  = 7'h68;
   localparam int         N_INIT = 3;
   localparam int         N_READ = 2;
   localparam logic [7:0] RBASE  = 8'h3B;
   localparam int         RD_W   = N_READ * 8;

   typedef struct {
      logic       r_en;
      logic [7:0] addr;
      logic [7:0] wdata;
   } txn_t;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic [N_INIT*8-1:0] init_addrs;
   logic [N_INIT*8-1:0] init_datas;
   logic                drv_req;
   logic [6:0]          drv_slave_addr;
   logic                drv_r_en;
   logic [7:0]          drv_reg_addr;
   logic [7:0]          drv_wdata;
   logic [7:0]          drv_rdata;
   logic                drv_done;
   logic                drv_nack;
   logic [RD_W-1:0]     rd_data;
   logic                rd_valid;
   logic                init_done;
   logic                busy;
   logic                error;

   txn_t            exp_q[$];
   logic [RD_W-1:0] exp_rd_q[$];
   int              n_checks = 0;
   int              n_pass   = 0;

   i2c_reg_sequencer #(
      .SLAVE_ADDR(SLAVE), .NUM_INIT(N_INIT), .NUM_READ(N_READ),
      .READ_BASE(RBASE), .POLL_DIV(10), .MAX_RETRY(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .init_addrs(init_addrs), .init_datas(init_datas),
      .drv_req(drv_req), .drv_slave_addr(drv_slave_addr), .drv_r_en(drv_r_en),
      .drv_reg_addr(drv_reg_addr), .drv_wdata(drv_wdata), .drv_rdata(drv_rdata),
      .drv_done(drv_done), .drv_nack(drv_nack),
      .rd_data(rd_data), .rd_valid(rd_valid), .init_done(init_done),
      .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic push_init(input int i);
      txn_t e;
      e.r_en  = 1'b0;
      e.addr  = init_addrs[8*i +: 8];
      e.wdata = init_datas[8*i +: 8];
      exp_q.push_back(e);
   endtask

   task automatic push_read(input int i);
      txn_t e;
      e.r_en  = 1'b1;
      e.addr  = RBASE + 8'(i);
      e.wdata = 8'h00;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for a request and match it against the scoreboard head.
   task automatic wait_req(output bit ok);
      int   n = 0;
      txn_t e;
      ok = 1'b0;
      while (!drv_req && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", drv_req, 1);
      if (!drv_req) return;
      if (exp_q.size() == 0) begin
         check("sb_underflow", 64'(exp_q.size()), 1);
         return;
      end
      e = exp_q.pop_front();
      check("txn", {drv_slave_addr, drv_r_en, drv_reg_addr, (drv_r_en ? 8'h00 : drv_wdata)},
                   {SLAVE, e.r_en, e.addr, (e.r_en ? 8'h00 : e.wdata)});
      ok = 1'b1;
   endtask

   // Behavioural driver: accept a request, hold a few cycles, pulse done.
   task automatic serve(input logic nack, input logic [7:0] rdata);
      bit          ok;
      logic [16:0] snap;
      wait_req(ok);
      if (!ok) return;
      snap = {drv_r_en, drv_reg_addr, drv_wdata};
      repeat (4) @(negedge clk);
      check("hold", {drv_req, drv_r_en, drv_reg_addr, drv_wdata}, {1'b1, snap});
      drv_done  = 1'b1;
      drv_nack  = nack;
      drv_rdata = rdata;
      @(negedge clk);
      drv_done  = 1'b0;
      drv_nack  = 1'b0;
      drv_rdata = 8'hEE;
      check("req_drop", drv_req, 0);
   endtask

   // Burst publication monitor.
   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         if (exp_rd_q.size() == 0) check("rd_valid_unexpected", rd_valid, 0);
         else check("rd_data", rd_data, exp_rd_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      int n;
      rst_n      = 1'b0;
      start      = 1'b0;
      drv_done   = 1'b0;
      drv_nack   = 1'b0;
      drv_rdata  = 8'h00;
      init_addrs = {8'h47, 8'h1C, 8'h6B};
      init_datas = {8'h00, 8'h08, 8'h00};
      repeat (3) @(negedge clk);
      check("rst_req", drv_req, 0);
      check("rst_slave", drv_slave_addr, SLAVE);
      check("rst_flags", {rd_valid, init_done, busy, error, drv_r_en}, 0);
      check("rst_operands", {drv_reg_addr, drv_wdata}, 0);
      check("rst_rd_data", rd_data, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // Init table, entry 1 NACKed twice then acked; a start mid-sequence is ignored.
      push_init(0); push_init(1); push_init(1); push_init(1); push_init(2);
      pulse_start();
      check("init_busy", busy, 1);
      serve(1'b0, 8'h00);
      pulse_start();
      serve(1'b1, 8'h00);
      serve(1'b1, 8'h00);
      serve(1'b0, 8'h00);
      check("init_done_early", init_done, 0);
      serve(1'b0, 8'h00);
      check("init_done_set", init_done, 1);
      check("init_no_error", error, 0);

      // First burst: 3B -> 12, 3C -> 34.
      push_read(0); push_read(1);
      exp_rd_q.push_back(16'h3412);
      serve(1'b0, 8'h12);
      serve(1'b0, 8'h34);
      check("rd_valid_pulse", rd_valid, 1);
      // Poll gap, with a stray done while no request is outstanding.
      n = 0;
      while (!drv_req && n < 50) begin
         drv_done = (n == 3);
         drv_nack = (n == 3);
         @(negedge clk);
         n++;
         if (n == 1) check("rd_valid_1cycle", rd_valid, 0);
      end
      drv_done = 1'b0;
      drv_nack = 1'b0;
      check("poll_gap", n, 11);

      // Second burst, clean.
      push_read(0); push_read(1);
      exp_rd_q.push_back(16'h7856);
      serve(1'b0, 8'h56);
      serve(1'b0, 8'h78);

      // Third burst: byte 1 NACKs until retries are exhausted.
      push_read(0);
      for (int i = 0; i < 4; i++) push_read(1);
      serve(1'b0, 8'hAA);
      for (int i = 0; i < 4; i++) serve(1'b1, 8'hBB);
      check("burst_err_error", error, 1);
      check("burst_err_busy", busy, 0);
      check("burst_err_rd_hold", rd_data, 16'h7856);
      repeat (15) @(negedge clk);
      check("err_parked", {drv_req, error}, 2'b01);

      // Restart from ERROR with a new table; entry 0 NACKs four times.
      init_addrs = {8'h56, 8'h34, 8'h12};
      init_datas = {8'hC3, 8'hB2, 8'hA1};
      for (int i = 0; i < 4; i++) push_init(0);
      pulse_start();
      check("restart_flags", {error, busy, init_done}, 3'b010);
      for (int i = 0; i < 4; i++) serve(1'b1, 8'h00);
      check("init_err_flags", {error, busy}, 2'b10);
      push_init(0); push_init(1); push_init(2);
      pulse_start();
      for (int i = 0; i < 3; i++) serve(1'b0, 8'h00);
      check("reinit_flags", {init_done, error}, 2'b10);

      // Reset asserted while a read request is outstanding.
      push_read(0); push_read(1);
      serve(1'b0, 8'h9A);
      wait_req(ok);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_req", drv_req, 0);
      check("async_rst_flags", {busy, init_done, error, rd_valid}, 0);
      check("async_rst_rd_data", rd_data, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      drv_done  = 1'b1;
      drv_rdata = 8'h55;
      @(negedge clk);
      drv_done = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_idle", {drv_req, busy, error, init_done}, 0);

      check("sb_txn_left", 64'(exp_q.size()), 0);
      check("sb_rd_left", 64'(exp_rd_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
- Parametrised I2C transaction sequencer.
- Issues a configurable table of NUM_INIT register writes to one slave, then runs periodic bursts of NUM_READ single-byte register reads.
- Sits between top-level glue and the byte-level i2c_driver; drives the driver's request/address/data inputs and collects its read data.
- Adds retry on NACK, error reporting and atomic multi-byte result publication.

Parameters:
- SLAVE_ADDR, 7'h68: 7-bit slave address driven on every transaction.
- NUM_INIT, 3: number of init write entries; legal range 1..16.
- NUM_READ, 6: bytes per read burst; legal range 1..16.
- READ_BASE, 8'h3B: register address of the first byte in each read burst.
- POLL_DIV, 12000: idle clk cycles between the end of one burst and the start of the next; must be >= 1.
- MAX_RETRY, 3: re-attempts per transaction after NACK before entering ERROR.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins init sequence from IDLE or ERROR, ignored otherwise
- init_addrs  in  NUM_INIT*8  entry i register address at [8*i+:8]; sampled at each issue
- init_datas  in  NUM_INIT*8  entry i write value at [8*i+:8]
- drv_req  out  1  transaction request to driver
- drv_slave_addr  out  7  always SLAVE_ADDR
- drv_r_en  out  1  1 = read, 0 = write
- drv_reg_addr  out  8  target register address
- drv_wdata  out  8  write byte
- drv_rdata  in  8  read byte from driver, valid when drv_done=1 and drv_r_en=1
- drv_done  in  1  one-cycle pulse; transaction finished
- drv_nack  in  1  qualified by drv_done; slave did not acknowledge
- rd_data  out  NUM_READ*8  last complete burst; byte i at [8*i+:8]
- rd_valid  out  1  one-cycle pulse when rd_data updates
- init_done  out  1  sticky; set when the init table completes
- busy  out  1  high in every state except IDLE and ERROR
- error  out  1  high while in ERROR

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all outputs 0 except drv_slave_addr=SLAVE_ADDR.
  - Internal indices, retry counter and poll timer cleared.
  - Reset mid-transaction drops drv_req immediately; any driver completion after release is ignored.
- States and transitions:
  - IDLE: on start -> INIT_ISSUE with idx=0.
  - INIT_ISSUE: drv_req=1, r_en=0, reg_addr/wdata from entry idx. Registered outputs; req rises the cycle after entry. -> INIT_WAIT.
  - INIT_WAIT:
    - Hold req and all operands stable until drv_done.
    - Done without nack: idx++, retry=0.
    - Done with nack: retry++; if retry exceeds MAX_RETRY -> ERROR, else reissue the same idx.
    - After the last entry: init_done=1 -> POLL_WAIT with timer=0.
  - POLL_WAIT: count clk cycles; at timer==POLL_DIV-1 -> READ_ISSUE with idx=0.
  - READ_ISSUE / READ_WAIT:
    - Same handshake as the init states, with r_en=1 and reg_addr=READ_BASE+idx (8-bit wrap, e.g. base FF, idx 1 -> 00).
    - On a clean done, drv_rdata goes to shadow byte idx.
    - After byte NUM_READ-1: copy shadow to rd_data in one cycle, pulse rd_valid -> POLL_WAIT with timer=0.
    - NACK retry rule as in INIT_WAIT; shadow is not published on error.
  - ERROR: error=1, req=0. On start: clear error, init_done=0, retry=0 -> INIT_ISSUE idx=0.
- Handshake:
  - drv_req deasserts the cycle after drv_done.
  - At least one idle cycle (req=0) between transactions, including retries.
- drv_done while req=0 is ignored.
- start while busy is ignored.
- rd_data holds its previous value until the next complete burst.

Test Plan:
- NUM_INIT=3, table {6B:00, 1C:08, 47:00}, driver acks with done after 5 cycles -> three writes in order, req low >=1 cycle between them, init_done rises after the third done.
- Continue with NUM_READ=2, READ_BASE=3B, drv_rdata 12 then 34, POLL_DIV=10 -> reads at 3B and 3C; rd_data=16'h3412; one rd_valid pulse; next burst req rises 11 cycles after the pulse.
- NACK on entry 1 twice, then ack (MAX_RETRY=3) -> entry 1 issued 3 times total, no error, sequence completes.
- NACK on entry 0 four times -> ERROR after the 4th done, error=1, busy=0, req=0; start -> restarts at entry 0 with error cleared.
- NACK exhausts retries mid-burst -> rd_data keeps prior value, no rd_valid pulse.
- rst_n low while drv_req=1 in READ_WAIT -> outputs zero same cycle; late drv_done ignored; state IDLE.
